// File: rtl/soc_mailbox_pkg.sv
// Shared definitions for the result mailbox: register offsets, FSM states
// and the byte-enable merge used by the RW registers.
package soc_mailbox_pkg;

    localparam logic [4:0] OFF_FLAG     = 5'h00;
    localparam logic [4:0] OFF_RESULT   = 5'h04;
    localparam logic [4:0] OFF_WR_COUNT = 5'h08;
    localparam logic [4:0] OFF_CYCLES   = 5'h0C;
    localparam logic [4:0] OFF_CTRL     = 5'h10;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_e;

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[i*8 +: 8] = be[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/soc_mailbox_bus_if.sv
// Data-port front end: address decode and the one-cycle response pipeline.
// Valid/ready: gnt mirrors req (never stalls); each granted request yields exactly one rvalid pulse on the next cycle.
module soc_mailbox_bus_if
    import soc_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        resp_err,
    input  logic [31:0] resp_rdata,
    output logic        gnt,
    output logic        hit,
    output logic [4:0]  offset,
    output logic        rvalid,
    output logic        err,
    output logic [31:0] rdata
);

    logic [31:0] rel_addr;

    assign rel_addr = addr - BASE_ADDR;
    assign offset   = rel_addr[4:0];
    assign hit      = (addr[1:0] == 2'b00) && (rel_addr[1:0] == 2'b00) &&
                      (rel_addr[31:5] == '0) && (rel_addr[4:0] <= OFF_CTRL);
    assign gnt      = req;

    // A request granted in the same cycle as reset is dropped with no response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= req;
            err    <= req & resp_err;
            rdata  <= req ? resp_rdata : '0;
        end
    end

endmodule

// File: rtl/soc_result_mailbox.sv
// Completion mailbox on the core data port: FLAG/RESULT registers, write and
// cycle counters, and a watchdog FSM that raises timeout_o on a hung program.
module soc_result_mailbox
    import soc_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int unsigned TIMEOUT   = 1000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [31:0] mem_flag_o,
    output logic [31:0] mem_result_o,
    output logic        timeout_o,
    output state_e      dbg_state_o
);

    localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

    logic             hit;
    logic [4:0]       offset;
    logic             acc_wr;
    logic             wr_flag;
    logic             wr_result;
    logic             ctrl_clr;
    logic             ro_write;
    logic             timeout_hit;
    logic             resp_err;
    logic [31:0]      resp_rdata;
    logic [31:0]      flag_next;
    logic [31:0]      flag_q;
    logic [31:0]      result_q;
    logic [31:0]      cycles_q;
    logic [CNT_W-1:0] wr_count_q;
    state_e           state_q;
    state_e           state_d;

    soc_mailbox_bus_if #(
        .BASE_ADDR(BASE_ADDR)
    ) u_bus_if (
        .clk       (clk_i),
        .rst       (rst_i),
        .req       (data_req_i),
        .addr      (data_addr_i),
        .resp_err  (resp_err),
        .resp_rdata(resp_rdata),
        .gnt       (data_gnt_o),
        .hit       (hit),
        .offset    (offset),
        .rvalid    (data_rvalid_o),
        .err       (data_err_o),
        .rdata     (data_rdata_o)
    );

    assign acc_wr      = data_req_i && hit && data_we_i;
    assign wr_flag     = acc_wr && (offset == OFF_FLAG);
    assign wr_result   = acc_wr && (offset == OFF_RESULT);
    assign ctrl_clr    = acc_wr && (offset == OFF_CTRL) && data_be_i[0] && data_wdata_i[0];
    assign ro_write    = acc_wr && ((offset == OFF_WR_COUNT) || (offset == OFF_CYCLES));
    assign resp_err    = !hit || ro_write;
    assign flag_next   = apply_be(flag_q, data_wdata_i, data_be_i);
    assign timeout_hit = (TIMEOUT != 0) && (cycles_q == TIMEOUT_M1);

    // Reads see the register contents before any write landing on this edge.
    always_comb begin
        resp_rdata = '0;
        if (data_req_i && hit && !data_we_i) begin
            case (offset)
                OFF_FLAG:     resp_rdata = flag_q;
                OFF_RESULT:   resp_rdata = result_q;
                OFF_WR_COUNT: resp_rdata = 32'(wr_count_q);
                OFF_CYCLES:   resp_rdata = cycles_q;
                default:      resp_rdata = '0;
            endcase
        end
    end

    // A FLAG set in the same cycle as watchdog expiry takes priority.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (wr_flag && (flag_next != '0)) state_d = ST_DONE;
                else if (timeout_hit)             state_d = ST_TIMEOUT;
            end
            ST_DONE: begin
                if (wr_flag && (flag_next == '0)) state_d = ST_RUN;
            end
            ST_TIMEOUT: state_d = ST_TIMEOUT;
            default:    state_d = ST_RUN;
        endcase
        if (ctrl_clr) state_d = ST_RUN;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || ctrl_clr) begin
            flag_q     <= '0;
            result_q   <= '0;
            cycles_q   <= '0;
            wr_count_q <= '0;
        end else begin
            if (wr_flag && (state_q != ST_TIMEOUT)) flag_q <= flag_next;
            if (wr_result) begin
                result_q <= apply_be(result_q, data_wdata_i, data_be_i);
                if (wr_count_q != {CNT_W{1'b1}}) wr_count_q <= wr_count_q + 1'b1;
            end
            if (state_q == ST_RUN) cycles_q <= cycles_q + 32'd1;
        end
    end

    assign mem_flag_o   = flag_q;
    assign mem_result_o = result_q;
    assign timeout_o    = (state_q == ST_TIMEOUT);
    assign dbg_state_o  = state_q;

endmodule
